// File: rtl/commit_monitor_pkg.sv
// Shared types for the commit monitor: trace entry layout, halt causes,
// core exception codes and the monitor state encoding.
package commit_pkg;

  localparam int TRACE_XLEN = 32;
  localparam int ARN_W      = 5;

  typedef enum logic [3:0] {
    NO_ERROR            = 4'd0,
    LOAD_ACCESS_FAULT   = 4'd1,
    STORE_ACCESS_FAULT  = 4'd2,
    ILLEGAL_INSTRUCTION = 4'd3,
    HALTED_ON_WFI       = 4'd4,
    HALTED_ON_EBREAK    = 4'd5
  } EXCEPTION_CODE;

  typedef struct packed {
    logic [TRACE_XLEN-1:0] pc;
    logic                  wr_en;
    logic [ARN_W-1:0]      arn;
    logic [TRACE_XLEN-1:0] data;
  } trace_entry_t;

  typedef enum logic [1:0] {
    HC_NONE  = 2'd0,
    HC_ERROR = 2'd1,
    HC_WDOG  = 2'd2
  } halt_cause_e;

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } mon_state_e;

  // A load access fault is recoverable by the core, so it is not fatal here.
  function automatic logic is_fatal(input EXCEPTION_CODE code);
    return (code != NO_ERROR) && (code != LOAD_ACCESS_FAULT);
  endfunction

endpackage

// File: rtl/commit_monitor_if.sv
// Commit-port and trace-port bundle between the core side (master) and the
// commit monitor (slave).
interface commit_monitor_if
  import commit_pkg::*;
#(
  parameter int WAYS  = 2,
  parameter int XLEN  = 32,
  parameter int DEPTH = 16
);

  logic [WAYS-1:0]         commit_valid;
  logic [WAYS*XLEN-1:0]    commit_pc;
  logic [WAYS-1:0]         commit_wr_en;
  logic [WAYS*ARN_W-1:0]   commit_arn;
  logic [WAYS*XLEN-1:0]    commit_data;
  EXCEPTION_CODE           error_status;
  logic                    trace_ready;
  logic                    trace_valid;
  trace_entry_t            trace_entry;
  logic [$clog2(DEPTH):0]  trace_count;
  logic                    stall_req;
  logic                    overflow;

  modport master (
    output commit_valid, commit_pc, commit_wr_en, commit_arn, commit_data,
           error_status, trace_ready,
    input  trace_valid, trace_entry, trace_count, stall_req, overflow
  );

  modport slave (
    input  commit_valid, commit_pc, commit_wr_en, commit_arn, commit_data,
           error_status, trace_ready,
    output trace_valid, trace_entry, trace_count, stall_req, overflow
  );

endinterface

// File: rtl/commit_monitor_trace_fifo.sv
// Circular trace buffer: up to WAYS compacted writes and one read per cycle;
// pointers carry an extra wrap bit so occupancy is their difference.
module commit_trace_fifo
  import commit_pkg::*;
#(
  parameter int WAYS  = 2,
  parameter int DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic [WAYS-1:0]        wr_mask,
  input  trace_entry_t           wr_data [WAYS],
  input  logic                   rd_en,
  output logic                   rd_valid,
  output trace_entry_t           rd_entry,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  trace_entry_t  mem [DEPTH];
  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic [CW-1:0] wr_num;
  logic [AW-1:0] wr_addr [WAYS];
  logic [AW-1:0] slot_ofs;
  logic          pop;

  // Each valid way takes the next free slot so invalid ways leave no holes.
  always_comb begin
    slot_ofs = '0;
    for (int w = 0; w < WAYS; w++) begin
      wr_addr[w] = wr_ptr[AW-1:0] + slot_ofs;
      slot_ofs   = slot_ofs + AW'(wr_mask[w]);
    end
  end

  assign wr_num   = CW'($countones(wr_mask));
  assign count    = wr_ptr - rd_ptr;
  assign rd_valid = (count != '0);
  assign rd_entry = mem[rd_ptr[AW-1:0]];
  assign pop      = rd_en && rd_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + wr_num;
      if (pop) rd_ptr <= rd_ptr + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    for (int w = 0; w < WAYS; w++) begin
      if (wr_mask[w] && !clear) mem[wr_addr[w]] <= wr_data[w];
    end
  end

endmodule

// File: rtl/commit_monitor.sv
// Retirement monitor on the ROB commit port: traces committed instructions,
// counts cycles/instructions and halts on fatal errors or commit starvation.
module commit_monitor
  import commit_pkg::*;
#(
  parameter int WAYS       = 2,
  parameter int XLEN       = 32,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = 64,
  parameter int WDOG_W     = 16,
  parameter int WDOG_LIMIT = 50000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  commit_monitor_if.slave   bus,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  instr_count,
  output logic              halt,
  output halt_cause_e       halt_cause
);

  localparam int CW = $clog2(DEPTH) + 1;

  mon_state_e        state;
  logic [WDOG_W-1:0] wdog;
  logic [WDOG_W-1:0] wdog_next;
  logic [CW-1:0]     n;
  logic [CW-1:0]     pop_n;
  logic [CW-1:0]     occ_next;
  logic              running;
  logic              fits;
  logic              accept;
  logic              drop;
  logic              wdog_hit;
  logic              stall_q;
  logic              overflow_q;
  logic [WAYS-1:0]   wr_mask;
  trace_entry_t      wr_data [WAYS];

  // A group is written whole or not at all, judged against post-pop occupancy.
  always_comb begin
    running  = (state == ST_RUN);
    n        = CW'($countones(bus.commit_valid));
    pop_n    = CW'(bus.trace_valid && bus.trace_ready);
    fits     = (bus.trace_count - pop_n + n) <= CW'(DEPTH);
    accept   = running && fits;
    drop     = running && !fits;
    wr_mask  = accept ? bus.commit_valid : '0;
    occ_next = bus.trace_count - pop_n + (accept ? n : '0);
    wdog_next = (n != '0)     ? '0 :
                (wdog == '1)  ? wdog : wdog + WDOG_W'(1);
    wdog_hit  = (wdog_next >= WDOG_W'(WDOG_LIMIT));
    for (int w = 0; w < WAYS; w++) begin
      wr_data[w].pc    = bus.commit_pc[w*XLEN +: XLEN];
      wr_data[w].wr_en = bus.commit_wr_en[w];
      wr_data[w].arn   = bus.commit_arn[w*ARN_W +: ARN_W];
      wr_data[w].data  = bus.commit_data[w*XLEN +: XLEN];
    end
  end

  commit_trace_fifo #(
    .WAYS  (WAYS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .clear    (clear),
    .wr_mask  (wr_mask),
    .wr_data  (wr_data),
    .rd_en    (bus.trace_ready),
    .rd_valid (bus.trace_valid),
    .rd_entry (bus.trace_entry),
    .count    (bus.trace_count)
  );

  // Error takes priority over the watchdog when both fire in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_RUN;
      cycle_count <= '0;
      instr_count <= '0;
      wdog        <= '0;
      halt        <= 1'b0;
      halt_cause  <= HC_NONE;
      overflow_q  <= 1'b0;
      stall_q     <= 1'b0;
    end else if (clear) begin
      state       <= ST_RUN;
      cycle_count <= '0;
      instr_count <= '0;
      wdog        <= '0;
      halt        <= 1'b0;
      halt_cause  <= HC_NONE;
      overflow_q  <= 1'b0;
      stall_q     <= 1'b0;
    end else begin
      stall_q <= (CW'(DEPTH) - occ_next) < CW'(WAYS);
      if (state == ST_RUN) begin
        cycle_count <= cycle_count + CNT_W'(1);
        instr_count <= instr_count + CNT_W'(n);
        wdog        <= wdog_next;
        if (drop) overflow_q <= 1'b1;
        if (is_fatal(bus.error_status)) begin
          state      <= ST_HALTED;
          halt       <= 1'b1;
          halt_cause <= HC_ERROR;
        end else if (wdog_hit) begin
          state      <= ST_HALTED;
          halt       <= 1'b1;
          halt_cause <= HC_WDOG;
        end
      end
    end
  end

  assign bus.stall_req = stall_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_commit_monitor.sv
// Scoreboard bench for commit_monitor: stimulus pushes expected trace entries,
// a negedge monitor pops and compares them as the FIFO drains.
module tb_commit_monitor;
  import commit_pkg::*;

  localparam int WAYS       = 2;
  localparam int XLEN       = 32;
  localparam int DEPTH      = 16;
  localparam int CNT_W      = 64;
  localparam int WDOG_W     = 16;
  localparam int WDOG_LIMIT = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             clear = 1'b0;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] instr_count;
  logic             halt;
  halt_cause_e      halt_cause;

  trace_entry_t expQ [$];
  int compared   = 0;
  int mismatched = 0;

  commit_monitor_if #(.WAYS(WAYS), .XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  commit_monitor #(
    .WAYS       (WAYS),
    .XLEN       (XLEN),
    .DEPTH      (DEPTH),
    .CNT_W      (CNT_W),
    .WDOG_W     (WDOG_W),
    .WDOG_LIMIT (WDOG_LIMIT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .clear       (clear),
    .bus         (bus),
    .cycle_count (cycle_count),
    .instr_count (instr_count),
    .halt        (halt),
    .halt_cause  (halt_cause)
  );

  always #5 clock = ~clock;

  function automatic trace_entry_t makeEntry(input logic [31:0] pc);
    trace_entry_t e;
    e.pc    = pc;
    e.wr_en = pc[2];
    e.arn   = pc[6:2];
    e.data  = {pc[15:0], ~pc[15:0]};
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one cycle of commit/trace inputs and records accepted entries.
  task automatic applyStimulus(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                               input logic rdy, input EXCEPTION_CODE err, input bit accepted);
    trace_entry_t e0, e1;
    e0 = makeEntry(pc0);
    e1 = makeEntry(pc1);
    bus.commit_valid = v;
    bus.commit_pc    = {e1.pc, e0.pc};
    bus.commit_wr_en = {e1.wr_en, e0.wr_en};
    bus.commit_arn   = {e1.arn, e0.arn};
    bus.commit_data  = {e1.data, e0.data};
    bus.trace_ready  = rdy;
    bus.error_status = err;
    if (accepted) begin
      if (v[0]) expQ.push_back(e0);
      if (v[1]) expQ.push_back(e1);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idleCycles(input int cycles, input logic rdy);
    for (int i = 0; i < cycles; i++) applyStimulus(2'b00, 32'h0, 32'h0, rdy, NO_ERROR, 1'b0);
  endtask

  task automatic doClear();
    clear = 1'b1;
    expQ.delete();
    applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, NO_ERROR, 1'b0);
    clear = 1'b0;
  endtask

  task automatic fillTo15(input logic [31:0] base);
    for (int i = 0; i < 7; i++)
      applyStimulus(2'b11, base + 32'(8*i), base + 32'(8*i + 4), 1'b0, NO_ERROR, 1'b1);
    checkOutput("stall_at_14", 64'(bus.stall_req), 64'd0);
    applyStimulus(2'b01, base + 32'h80, 32'h0, 1'b0, NO_ERROR, 1'b1);
    checkOutput("count_15", 64'(bus.trace_count), 64'd15);
    checkOutput("stall_at_15", 64'(bus.stall_req), 64'd1);
  endtask

  always @(negedge clock) begin
    if (reset && !clear && bus.trace_valid && bus.trace_ready) begin
      compared++;
      if (expQ.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL trace_unexpected: got %h expected no entry", bus.trace_entry);
      end else begin
        trace_entry_t exp;
        exp = expQ.pop_front();
        if (bus.trace_entry !== exp) begin
          mismatched++;
          $display("[TB] FAIL trace_entry: got %h expected %h", bus.trace_entry, exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time bound");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bus.commit_valid = '0;
    bus.commit_pc    = '0;
    bus.commit_wr_en = '0;
    bus.commit_arn   = '0;
    bus.commit_data  = '0;
    bus.trace_ready  = 1'b0;
    bus.error_status = NO_ERROR;
    #2 reset = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    checkOutput("rst_trace_valid", 64'(bus.trace_valid), 64'd0);
    checkOutput("rst_trace_count", 64'(bus.trace_count), 64'd0);
    checkOutput("rst_stall", 64'(bus.stall_req), 64'd0);
    checkOutput("rst_overflow", 64'(bus.overflow), 64'd0);
    checkOutput("rst_cycle", cycle_count, 64'd0);
    checkOutput("rst_instr", instr_count, 64'd0);
    checkOutput("rst_halt", 64'(halt), 64'd0);
    checkOutput("rst_cause", 64'(halt_cause), 64'(HC_NONE));
    reset = 1'b1;

    $display("[TB] three 2-wide groups with no pop");
    for (int i = 0; i < 3; i++) applyStimulus(2'b11, 32'h0, 32'h4, 1'b0, NO_ERROR, 1'b1);
    checkOutput("t1_count", 64'(bus.trace_count), 64'd6);
    checkOutput("t1_instr", instr_count, 64'd6);
    checkOutput("t1_cycle", cycle_count, 64'd3);
    checkOutput("t1_head_pc", 64'(bus.trace_entry.pc), 64'h0);
    checkOutput("t1_stall", 64'(bus.stall_req), 64'd0);
    idleCycles(6, 1'b1);
    checkOutput("t1_drained", 64'(bus.trace_count), 64'd0);
    checkOutput("t1_queue", 64'(expQ.size()), 64'd0);

    $display("[TB] sparse group on way 1 only");
    doClear();
    applyStimulus(2'b10, 32'hDEAD0000, 32'h100, 1'b0, LOAD_ACCESS_FAULT, 1'b1);
    checkOutput("t2_count", 64'(bus.trace_count), 64'd1);
    checkOutput("t2_instr", instr_count, 64'd1);
    checkOutput("t2_no_halt", 64'(halt), 64'd0);
    idleCycles(1, 1'b1);
    checkOutput("t2_drained", 64'(bus.trace_count), 64'd0);
    checkOutput("t2_queue", 64'(expQ.size()), 64'd0);

    $display("[TB] group dropped when FIFO cannot hold it");
    doClear();
    fillTo15(32'h1000);
    applyStimulus(2'b11, 32'h1F00, 32'h1F04, 1'b0, NO_ERROR, 1'b0);
    checkOutput("t3_count", 64'(bus.trace_count), 64'd15);
    checkOutput("t3_overflow", 64'(bus.overflow), 64'd1);
    checkOutput("t3_instr", instr_count, 64'd17);
    checkOutput("t3_cycle", cycle_count, 64'd9);
    checkOutput("t3_stall", 64'(bus.stall_req), 64'd1);
    idleCycles(15, 1'b1);
    checkOutput("t3_drained", 64'(bus.trace_count), 64'd0);
    checkOutput("t3_queue", 64'(expQ.size()), 64'd0);
    checkOutput("t3_ovf_sticky", 64'(bus.overflow), 64'd1);

    $display("[TB] group accepted thanks to same-cycle pop");
    doClear();
    checkOutput("t4_ovf_cleared", 64'(bus.overflow), 64'd0);
    fillTo15(32'h5000);
    applyStimulus(2'b11, 32'h5F00, 32'h5F04, 1'b1, NO_ERROR, 1'b1);
    checkOutput("t4_count", 64'(bus.trace_count), 64'd16);
    checkOutput("t4_overflow", 64'(bus.overflow), 64'd0);
    checkOutput("t4_stall", 64'(bus.stall_req), 64'd1);
    idleCycles(16, 1'b1);
    checkOutput("t4_drained", 64'(bus.trace_count), 64'd0);
    checkOutput("t4_queue", 64'(expQ.size()), 64'd0);

    $display("[TB] fatal error halt");
    doClear();
    applyStimulus(2'b11, 32'h2000, 32'h2004, 1'b0, HALTED_ON_WFI, 1'b1);
    checkOutput("t5_halt", 64'(halt), 64'd1);
    checkOutput("t5_cause", 64'(halt_cause), 64'(HC_ERROR));
    checkOutput("t5_count", 64'(bus.trace_count), 64'd2);
    checkOutput("t5_instr", instr_count, 64'd2);
    applyStimulus(2'b11, 32'h3000, 32'h3004, 1'b0, NO_ERROR, 1'b0);
    checkOutput("t5_frozen_count", 64'(bus.trace_count), 64'd2);
    checkOutput("t5_frozen_instr", instr_count, 64'd2);
    checkOutput("t5_frozen_cycle", cycle_count, 64'd1);
    checkOutput("t5_no_overflow", 64'(bus.overflow), 64'd0);
    idleCycles(2, 1'b1);
    checkOutput("t5_drained", 64'(bus.trace_count), 64'd0);
    checkOutput("t5_queue", 64'(expQ.size()), 64'd0);
    checkOutput("t5_cause_stable", 64'(halt_cause), 64'(HC_ERROR));

    $display("[TB] watchdog");
    doClear();
    idleCycles(7, 1'b0);
    checkOutput("t6_no_halt_7", 64'(halt), 64'd0);
    idleCycles(1, 1'b0);
    checkOutput("t6_halt_8", 64'(halt), 64'd1);
    checkOutput("t6_cause", 64'(halt_cause), 64'(HC_WDOG));
    checkOutput("t6_cycle", cycle_count, 64'd8);
    idleCycles(2, 1'b0);
    checkOutput("t6_cycle_frozen", cycle_count, 64'd8);
    doClear();
    idleCycles(6, 1'b0);
    applyStimulus(2'b01, 32'h4000, 32'h0, 1'b0, NO_ERROR, 1'b1);
    idleCycles(1, 1'b0);
    checkOutput("t6_kick_no_halt", 64'(halt), 64'd0);
    checkOutput("t6_kick_cycle", cycle_count, 64'd8);
    checkOutput("t6_kick_instr", instr_count, 64'd1);

    $display("[TB] error and watchdog in the same cycle");
    doClear();
    idleCycles(7, 1'b0);
    applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, ILLEGAL_INSTRUCTION, 1'b0);
    checkOutput("t7_halt", 64'(halt), 64'd1);
    checkOutput("t7_cause", 64'(halt_cause), 64'(HC_ERROR));

    $display("[TB] reset mid-fill");
    doClear();
    for (int i = 0; i < 3; i++) applyStimulus(2'b11, 32'h6000, 32'h6004, 1'b0, NO_ERROR, 1'b1);
    checkOutput("t8_count_pre", 64'(bus.trace_count), 64'd6);
    reset = 1'b0;
    expQ.delete();
    #1;
    checkOutput("t8_valid", 64'(bus.trace_valid), 64'd0);
    checkOutput("t8_count", 64'(bus.trace_count), 64'd0);
    checkOutput("t8_instr", instr_count, 64'd0);
    checkOutput("t8_cycle", cycle_count, 64'd0);
    checkOutput("t8_stall", 64'(bus.stall_req), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    idleCycles(1, 1'b1);
    checkOutput("t8_after_release", 64'(bus.trace_count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
